// File: rtl/commit_sequencer.sv
// commit_sequencer: seven-entry in-order commit buffer that hands out tags
// 1..7, captures out-of-order writebacks and retires one result per cycle
// to the register file.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   pause, flush  freeze the sequencer / discard every in-flight entry
//   issue_*       tag request from the decoder; issue_tag is the tag granted
//   wb_*          execution results, addressed by tag
//   rf_*          register-file write port and retiring tag (rf_num)
//   count         number of occupied entries
module commit_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic              flush,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   output logic              issue_ready,
   output logic [2:0]        issue_tag,
   input  logic              wb_valid,
   input  logic [2:0]        wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_commit,
   output logic [4:0]        rf_reg_num,
   output logic [DATA_W-1:0] rf_data,
   output logic [2:0]        rf_num,
   output logic [2:0]        count
);

   // Slot 0 exists only so a tag of 0 indexes a permanently invalid entry.
   logic [7:0]        vld;
   logic [7:0]        rdy;
   logic [4:0]        rd_q   [8];
   logic [DATA_W-1:0] data_q [8];

   logic [2:0] head;
   logic [2:0] tail;

   logic do_issue;
   logic do_wb;
   logic do_ret;

   function automatic logic [2:0] next_ptr(input logic [2:0] p);
      return (p == 3'd7) ? 3'd1 : p + 3'd1;
   endfunction

   assign issue_ready = (count != 3'd7) && !pause && !flush;
   assign issue_tag   = tail;

   assign do_issue = issue_valid && issue_ready;
   assign do_wb    = wb_valid && vld[wb_tag] && !pause && !flush;
   // Readiness is the pre-edge value, so a writeback never retires
   // on the same edge it lands.
   assign do_ret   = vld[head] && rdy[head] && !pause && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld        <= '0;
         rdy        <= '0;
         head       <= 3'd1;
         tail       <= 3'd1;
         count      <= '0;
         rf_commit  <= 1'b0;
         rf_reg_num <= '0;
         rf_data    <= '0;
         rf_num     <= '0;
         for (int i = 0; i < 8; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else if (flush) begin
         vld       <= '0;
         rdy       <= '0;
         head      <= 3'd1;
         tail      <= 3'd1;
         count     <= '0;
         rf_commit <= 1'b0;
      end else if (pause) begin
         rf_commit <= 1'b0;
      end else begin
         if (do_wb) begin
            data_q[wb_tag] <= wb_data;
            rdy[wb_tag]    <= 1'b1;
         end
         // Tail can only equal head here when the buffer is empty, so an
         // issue never lands on the entry being retired.
         if (do_issue) begin
            vld[tail]  <= 1'b1;
            rdy[tail]  <= 1'b0;
            rd_q[tail] <= issue_rd;
            tail       <= next_ptr(tail);
         end
         if (do_ret) begin
            vld[head]  <= 1'b0;
            rdy[head]  <= 1'b0;
            head       <= next_ptr(head);
            // x0 retires silently: the entry drains but no write strobe.
            rf_commit  <= (rd_q[head] != 5'd0);
            rf_reg_num <= rd_q[head];
            rf_data    <= data_q[head];
            rf_num     <= head;
         end else begin
            rf_commit <= 1'b0;
         end
         count <= count + {2'b00, do_issue} - {2'b00, do_ret};
      end
   end

endmodule
